// File: rtl/mdio_master_pkg.sv
// Shared constants for the Clause-22 MDIO master: opcodes, state encoding, phase lengths.
package mdio_master_pkg;

    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_ST    = 2'b01;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_PRE  = 3'd1;
    localparam state_t S_HDR  = 3'd2;
    localparam state_t S_TA   = 3'd3;
    localparam state_t S_DATA = 3'd4;
    localparam state_t S_DONE = 3'd5;

    localparam int HDR_LEN  = 14;
    localparam int TA_LEN   = 2;
    localparam int DATA_LEN = 16;

    function automatic logic op_valid(input logic [1:0] op);
        return (op == MDIO_OP_WR) || (op == MDIO_OP_RD);
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: low for CLK_DIV cycles, then high for CLK_DIV cycles, while enabled.
// fall_stb/rise_stb flag the cycle before mdc toggles, so registered pin logic moves with mdc.
module mdio_clk_gen #(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic mdc,
    output logic fall_stb,
    output logic rise_stb
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap     = en && (cnt == CW'(CLK_DIV - 1));
    assign rise_stb = wrap && !mdc;
    assign fall_stb = wrap && mdc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            mdc <= ~mdc;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: frame sequencer and shift registers around mdio_clk_gen.
// Define MDIO_MASTER_TA_CHECK_EN to flag reads where no PHY pulls the second TA bit low.
module mdio_master
    import mdio_master_pkg::*;
#(
    parameter int CLK_DIV      = 20,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_t,
    input  logic        mdio_in
);
    state_t      state;
    logic [5:0]  bit_cnt;
    logic [31:0] tx_sr;
    logic [15:0] rx_sr;
    logic [31:0] frame;
    logic        is_read;
    logic        ta_fail;
    logic        fall_stb;
    logic        rise_stb;
    logic        accept;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = ~cmd_ready;
    assign rsp_valid = (state == S_DONE);
    assign accept    = cmd_valid & cmd_ready;

    // Everything after the preamble; TA is 1,0 for writes and don't-care (released) for reads.
    assign frame = {MDIO_ST, cmd_op, cmd_phy, cmd_reg,
                    ((cmd_op == MDIO_OP_RD) ? 2'b11 : 2'b10), cmd_wdata};

    mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (busy),
        .mdc      (mdc),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            is_read   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mdio_out  <= 1'b1;
            mdio_t    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    is_read <= (cmd_op == MDIO_OP_RD);
                    if (!op_valid(cmd_op)) begin
                        state     <= S_DONE;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else if (PREAMBLE_LEN == 0) begin
                        state    <= S_HDR;
                        bit_cnt  <= 6'(HDR_LEN - 1);
                        mdio_t   <= 1'b0;
                        mdio_out <= frame[31];
                        tx_sr    <= {frame[30:0], 1'b0};
                    end else begin
                        state    <= S_PRE;
                        bit_cnt  <= 6'(PREAMBLE_LEN - 1);
                        mdio_t   <= 1'b0;
                        mdio_out <= 1'b1;
                        tx_sr    <= frame;
                    end
                end
                S_PRE: if (fall_stb) begin
                    if (bit_cnt == 6'd0) begin
                        state    <= S_HDR;
                        bit_cnt  <= 6'(HDR_LEN - 1);
                        mdio_out <= tx_sr[31];
                        tx_sr    <= {tx_sr[30:0], 1'b0};
                    end else begin
                        bit_cnt <= bit_cnt - 6'd1;
                    end
                end
                S_HDR: if (fall_stb) begin
                    mdio_out <= tx_sr[31];
                    tx_sr    <= {tx_sr[30:0], 1'b0};
                    if (bit_cnt == 6'd0) begin
                        state   <= S_TA;
                        bit_cnt <= 6'(TA_LEN - 1);
                        mdio_t  <= is_read;
                    end else begin
                        bit_cnt <= bit_cnt - 6'd1;
                    end
                end
                S_TA: if (fall_stb) begin
                    mdio_out <= tx_sr[31];
                    tx_sr    <= {tx_sr[30:0], 1'b0};
                    if (bit_cnt == 6'd0) begin
                        state   <= S_DATA;
                        bit_cnt <= 6'(DATA_LEN - 1);
                    end else begin
                        bit_cnt <= bit_cnt - 6'd1;
                    end
                end
                S_DATA: if (fall_stb) begin
                    if (bit_cnt == 6'd0) begin
                        state     <= S_DONE;
                        mdio_t    <= 1'b1;
                        mdio_out  <= 1'b1;
                        rsp_rdata <= is_read ? rx_sr : 16'h0000;
                        rsp_err   <= ta_fail;
                    end else begin
                        bit_cnt  <= bit_cnt - 6'd1;
                        mdio_out <= tx_sr[31];
                        tx_sr    <= {tx_sr[30:0], 1'b0};
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // The last read bit is sampled on its rising edge, a half period before DONE reads rx_sr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sr <= '0;
        end else if (state == S_DATA && is_read && rise_stb) begin
            rx_sr <= {rx_sr[14:0], mdio_in};
        end
    end

`ifdef MDIO_MASTER_TA_CHECK_EN
    logic ta_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ta_bad <= 1'b0;
        end else if (accept) begin
            ta_bad <= 1'b0;
        end else if (state == S_TA && rise_stb && bit_cnt == 6'd0) begin
            ta_bad <= mdio_in;
        end
    end

    assign ta_fail = is_read & ta_bad;
`else
    assign ta_fail = 1'b0;
`endif

endmodule

// File: doc/mdio_master.md
# mdio_master

Clause-22 MDIO management master that sequences a single bidirectional management pin through the common `xil_iobuf` (DATA_WIDTH=1). It accepts register read/write commands over a valid/ready handshake and generates MDC. It serialises the 32-bit preamble and frame, and turns the pin around for read data. It returns one response per command. It sits between the board-control register file and the external PHY management pins.

## Interface
- `CLK_DIV`, 20: MDC half-period in `clk` cycles, ≥2; bit period = 2·CLK_DIV.
- `PREAMBLE_LEN`, 32: number of leading '1' bits, 0..32.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE; a command is accepted when `cmd_valid & cmd_ready`.
- `cmd_op` in 2: 2'b01 write, 2'b10 read; other values are invalid.
- `cmd_phy` in 5: PHY address.
- `cmd_reg` in 5: register address.
- `cmd_wdata` in 16: write data.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 16: read data; 0 for writes and invalid ops; held until the next response.
- `rsp_err` out 1: response error flag; held with `rsp_rdata`.
- `busy` out 1: high in any state other than IDLE.
- `mdc` out 1: management clock.
- `mdio_out` out 1: to iobuf I.
- `mdio_t` out 1: to iobuf T; 1 = released (input), 0 = driven.
- `mdio_in` in 1: from iobuf O.

## Operation
- States: IDLE, PRE, HDR, TA, DATA, DONE.
- IDLE: `mdc`=0, `mdio_t`=1, `mdio_out`=1.
- On accept, command fields are latched.
  - Valid op: go to PRE, or straight to HDR if PREAMBLE_LEN=0.
  - Invalid op: go to DONE with `rsp_err`=1, no pin activity.
- PRE: drive '1' for PREAMBLE_LEN bits.
- HDR: drive 14 bits MSB first: ST=01, OP, PHYAD, REGAD.
- TA:
  - Write: drive 1,0.
  - Read: `mdio_t`=1 for both TA bits.
- DATA:
  - Write: drive `cmd_wdata[15:0]` MSB first.
  - Read: stay released and shift in 16 bits MSB first.
- DONE: pulse `rsp_valid` for one cycle, release the pin, return to IDLE.
- After DONE, `mdio_t`=1 until the next frame.
- Bit counter: 6 bits, counts down within each phase, and reloads on each phase transition.
- A command presented while busy is not accepted. `cmd_valid` may stay high and is taken on the first IDLE cycle.

## Timing
- Each bit period starts with `mdc` low for CLK_DIV cycles, then high for CLK_DIV cycles.
- Driven bits change on the cycle `mdc` falls, and at frame start.
- Read bits are sampled from `mdio_in` on the cycle `mdc` rises.
- The first frame bit starts the cycle after accept.
- Latency from accept cycle to `rsp_valid` = (PREAMBLE_LEN+32)·2·CLK_DIV + 1 cycles.
  - Invalid op: `rsp_valid` occurs 1 cycle after accept.
- Back-to-back: IDLE lasts ≥1 cycle between frames, with `mdc` low.
- Reset values: `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mdc`=0, `mdio_out`=1, `mdio_t`=1.
- Reset mid-frame: the pin is released immediately and no response is issued. The partial frame is abandoned.

## Configuration
- `MDIO_MASTER_TA_CHECK_EN` defined:
  - On a read, `mdio_in` is sampled at the second TA bit.
  - If it is 1 (no PHY drove 0), `rsp_err`=1.
  - Data is still captured.
- Not defined: `rsp_err` is set only for invalid ops.

## Structure
- Package `mdio_master_pkg`:
  - opcode constants `MDIO_OP_WR`=2'b01, `MDIO_OP_RD`=2'b10, `MDIO_ST`=2'b01;
  - state enum;
  - phase lengths HDR=14, TA=2, DATA=16.
- Sub-module `mdio_clk_gen`:
  - divider enabled while busy;
  - outputs `mdc`, a one-cycle `fall_stb` and a one-cycle `rise_stb`;
  - counter clears on disable.
- Top-level FSM and shift registers live in `mdio_master`. The system top instantiates `xil_iobuf` on the pin.

## Test plan
- CLK_DIV=2, write phy=5'h01 reg=5'h04 data=16'hA5C3:
  - pin shows 32 ones, then 01 01 00001 00100 10 1010010111000011 on `mdc` rises;
  - `mdio_t`=0 throughout;
  - `rsp_valid` at accept+257, `rsp_err`=0.
- Read phy=5'h1F reg=5'h01 with PHY model driving TA 0 and data 16'h796D:
  - `mdio_t` goes to 1 from the TA start;
  - `rsp_rdata`=16'h796D, `rsp_err`=0.
- With `MDIO_MASTER_TA_CHECK_EN`, read with no PHY (pull-up model, `mdio_in`=1):
  - `rsp_rdata`=16'hFFFF, `rsp_err`=1.
- `cmd_op`=2'b11:
  - `rsp_valid` one cycle after accept, `rsp_err`=1;
  - `mdc` stays 0, `mdio_t` stays 1.
- Two commands with `cmd_valid` held high:
  - second is accepted exactly one IDLE cycle after the first `rsp_valid`;
  - `cmd_ready`=0 throughout each frame.
- Assert `rst` during HDR of a write:
  - same cycle: `mdio_t`=1, `mdc`=0;
  - no `rsp_valid`;
  - `cmd_ready`=1 after release, and the next write completes normally.
